// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped branch target buffer with 2-bit direction counters
//
// Purpose:
//   Predicts the direction and target of control-flow instructions for the
//   fetch stage.
//   - Lookup is combinational. Its result is taken from the table contents
//     as they stand before the clock edge.
//   - The execute stage trains the table once per resolved branch or jump.
//   - The same resolve port raises the mispredict/recovery pair for the PC.
//   All PCs are word addresses (byte PC bits [31:2]).
//
// Ports:
//   CLK             in   1   clock, all state changes on the rising edge
//   RST             in   1   synchronous active-high reset
//   lookup_en       in   1   fetch_pc is valid this cycle
//   fetch_pc        in   30  fetch word PC
//   bpSel           out  1   predicted taken, fetch redirects to bp_a
//   bp_a            out  30  predicted target word PC (0 on miss)
//   res_valid       in   1   a control-flow instruction resolves this cycle
//   res_pc          in   30  word PC of the resolving instruction
//   res_taken       in   1   actual direction
//   res_target      in   30  actual target word PC
//   res_pred_taken  in   1   bpSel carried down the pipe with the instruction
//   res_pred_target in   30  bp_a carried down the pipe with the instruction
//   pdStatus        out  1   mispredict, fetch must load rpc
//   rpc             out  30  recovery word PC (0 when no mispredict)
//   mp_count        out  32  saturating mispredict counter

module branch_target_buffer #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        lookup_en,
   input  logic [29:0] fetch_pc,
   output logic        bpSel,
   output logic [29:0] bp_a,
   input  logic        res_valid,
   input  logic [29:0] res_pc,
   input  logic        res_taken,
   input  logic [29:0] res_target,
   input  logic        res_pred_taken,
   input  logic [29:0] res_pred_target,
   output logic        pdStatus,
   output logic [29:0] rpc,
   output logic [31:0] mp_count
);

   localparam int TAG_W = 30 - IDX_W;

   logic               r_valid  [ENTRIES];
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [29:0]        r_target [ENTRIES];
   logic [1:0]         r_ctr    [ENTRIES];
   logic [31:0]        r_mp_count;

   logic [IDX_W-1:0]   w_lk_idx;
   logic [TAG_W-1:0]   w_lk_tag;
   logic               w_lk_hit;

   logic [IDX_W-1:0]   w_rs_idx;
   logic [TAG_W-1:0]   w_rs_tag;
   logic               w_rs_hit;
   logic               w_rs_upd;
   logic               w_mispredict;

   // Lookup path: reads only registered state, so a same-cycle update to the
   // same index is not seen until the following cycle.
   assign w_lk_idx = fetch_pc[IDX_W-1:0];
   assign w_lk_tag = fetch_pc[29:IDX_W];
   assign w_lk_hit = lookup_en & r_valid[w_lk_idx] & (r_tag[w_lk_idx] == w_lk_tag);

   assign bpSel = w_lk_hit & r_ctr[w_lk_idx][1];
   assign bp_a  = w_lk_hit ? r_target[w_lk_idx] : 30'd0;

   // Resolve path
   assign w_rs_idx = res_pc[IDX_W-1:0];
   assign w_rs_tag = res_pc[29:IDX_W];
   assign w_rs_hit = r_valid[w_rs_idx] & (r_tag[w_rs_idx] == w_rs_tag);
   assign w_rs_upd = res_valid & ~RST;

   // A taken branch that was also predicted taken still mispredicts if the
   // carried-down target differs from the real one (e.g. an indirect jump).
   assign w_mispredict = (res_taken != res_pred_taken) |
                         (res_taken & res_pred_taken & (res_target != res_pred_target));

   assign pdStatus = w_rs_upd & w_mispredict;
   // Not-taken recovery falls through to res_pc + 1; the 30-bit add wraps naturally.
   assign rpc      = pdStatus ? (res_taken ? res_target : res_pc + 30'd1) : 30'd0;
   assign mp_count = r_mp_count;

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= 30'd0;
            r_ctr[i]    <= 2'b01;
         end
      end else if (res_valid) begin
         if (w_rs_hit) begin
            if (res_taken) begin
               if (r_ctr[w_rs_idx] != 2'b11)
                  r_ctr[w_rs_idx] <= r_ctr[w_rs_idx] + 2'd1;
               r_target[w_rs_idx] <= res_target;
            end else if (r_ctr[w_rs_idx] != 2'b00) begin
               r_ctr[w_rs_idx] <= r_ctr[w_rs_idx] - 2'd1;
            end
         end else if (res_taken) begin
            // Allocate on a taken miss, evicting whatever aliased here.
            // Start the counter weakly taken.
            r_valid[w_rs_idx]  <= 1'b1;
            r_tag[w_rs_idx]    <= w_rs_tag;
            r_target[w_rs_idx] <= res_target;
            r_ctr[w_rs_idx]    <= 2'b10;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST)
         r_mp_count <= 32'd0;
      else if (pdStatus && (r_mp_count != 32'hFFFF_FFFF))
         r_mp_count <= r_mp_count + 32'd1;
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - directed and randomized self-checking bench for branch_target_buffer

module tb_branch_target_buffer;

   logic        CLK = 1'b0;
   logic        RST;
   logic        lookup_en;
   logic [29:0] fetch_pc;
   logic        bpSel;
   logic [29:0] bp_a;
   logic        res_valid;
   logic [29:0] res_pc;
   logic        res_taken;
   logic [29:0] res_target;
   logic        res_pred_taken;
   logic [29:0] res_pred_target;
   logic        pdStatus;
   logic [29:0] rpc;
   logic [31:0] mp_count;

   int n_cmp = 0;
   int n_err = 0;

   // Reference table, indexed by pc % 16 with tag pc / 16
   bit          m_valid [16];
   longint      m_tag   [16];
   longint      m_tgt   [16];
   int          m_ctr   [16];
   longint      m_mp;

   // Outputs captured in the last cycle, before its clock edge
   logic        o_bpsel;
   logic [29:0] o_bpa;
   logic        o_pd;
   logic [29:0] o_rpc;

   branch_target_buffer #(.ENTRIES(16)) dut (
      .CLK(CLK), .RST(RST), .lookup_en(lookup_en), .fetch_pc(fetch_pc),
      .bpSel(bpSel), .bp_a(bp_a), .res_valid(res_valid), .res_pc(res_pc),
      .res_taken(res_taken), .res_target(res_target),
      .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
      .pdStatus(pdStatus), .rpc(rpc), .mp_count(mp_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_hit(input longint pc);
      return m_valid[pc % 16] && (m_tag[pc % 16] == pc / 16);
   endfunction

   function automatic bit m_pred_taken(input longint pc);
      return m_hit(pc) && (m_ctr[pc % 16] >= 2);
   endfunction

   function automatic longint m_pred_target(input longint pc);
      return m_hit(pc) ? m_tgt[pc % 16] : 0;
   endfunction

   // One clock: apply inputs, check combinational outputs, clock, advance model, check counter
   task automatic cycle(input bit rst, input bit le, input longint fpc,
                        input bit rv, input longint rp, input bit rt, input longint rtg,
                        input bit pt, input longint ptg);
      bit     e_pd;
      longint e_rpc;
      longint i;
      RST = rst; lookup_en = le; fetch_pc = 30'(fpc);
      res_valid = rv; res_pc = 30'(rp); res_taken = rt; res_target = 30'(rtg);
      res_pred_taken = pt; res_pred_target = 30'(ptg);
      #1;
      e_pd  = !rst && rv && ((rt != pt) || (rt && pt && rtg != ptg));
      e_rpc = !e_pd ? 0 : (rt ? rtg : (rp + 1) % (64'd1 << 30));
      o_bpsel = bpSel; o_bpa = bp_a; o_pd = pdStatus; o_rpc = rpc;
      check("bpSel", 32'(bpSel), 32'(le && m_pred_taken(fpc)));
      check("bp_a", 32'(bp_a), 32'(le ? m_pred_target(fpc) : 0));
      check("pdStatus", 32'(pdStatus), 32'(e_pd));
      check("rpc", 32'(rpc), 32'(e_rpc));
      @(posedge CLK);
      if (rst) begin
         for (int k = 0; k < 16; k++) begin
            m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_ctr[k] = 1;
         end
         m_mp = 0;
      end else if (rv) begin
         i = rp % 16;
         if (m_hit(rp)) begin
            if (rt) begin
               m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
               m_tgt[i] = rtg;
            end else begin
               m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
         end else if (rt) begin
            m_valid[i] = 1; m_tag[i] = rp / 16; m_tgt[i] = rtg; m_ctr[i] = 2;
         end
         if (e_pd && m_mp < 64'hFFFF_FFFF) m_mp++;
      end
      #1;
      check("mp_count", mp_count, 32'(m_mp));
   endtask

   task automatic lookup(input longint fpc);
      cycle(0, 1, fpc, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic resolve(input longint rp, input bit rt, input longint rtg,
                          input bit pt, input longint ptg);
      cycle(0, 0, 0, 1, rp, rt, rtg, pt, ptg);
   endtask

   initial begin
      longint pc, tgt;
      bit     rt, pt;
      longint ptg;
      RST = 1; lookup_en = 0; fetch_pc = 0; res_valid = 0; res_pc = 0;
      res_taken = 0; res_target = 0; res_pred_taken = 0; res_pred_target = 0;
      m_mp = 0;
      @(negedge CLK);

      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      // After reset everything misses
      lookup(30'h40);
      check("tp_reset_bpsel", 32'(o_bpsel), 32'd0);
      check("tp_reset_bpa", 32'(o_bpa), 32'd0);
      check("tp_reset_mp", mp_count, 32'd0);

      // First taken resolve allocates and mispredicts
      resolve(30'h10, 1, 30'h80, 0, 0);
      check("tp_alloc_pd", 32'(o_pd), 32'd1);
      check("tp_alloc_rpc", 32'(o_rpc), 32'h80);
      lookup(30'h10);
      check("tp_alloc_bpsel", 32'(o_bpsel), 32'd1);
      check("tp_alloc_bpa", 32'(o_bpa), 32'h80);
      check("tp_alloc_mp", mp_count, 32'd1);

      // Not taken: recover to fall-through, counter weakens to 01
      resolve(30'h10, 0, 0, 1, 30'h80);
      check("tp_nt_rpc", 32'(o_rpc), 32'h11);
      lookup(30'h10);
      check("tp_nt_bpsel", 32'(o_bpsel), 32'd0);

      // Aliasing on index 0
      resolve(30'h10, 1, 30'h80, 0, 0);
      lookup(30'h20);
      check("tp_alias_miss", 32'(o_bpsel), 32'd0);
      resolve(30'h20, 1, 30'h5, 0, 0);
      lookup(30'h20);
      check("tp_alias_bpa", 32'(o_bpa), 32'h5);
      lookup(30'h10);
      check("tp_alias_evict", 32'(o_bpsel), 32'd0);

      // Saturation then one not-taken leaves the entry predicting taken
      for (int k = 0; k < 4; k++) resolve(30'h10, 1, 30'h80, 1, 30'h80);
      resolve(30'h10, 0, 0, 1, 30'h80);
      lookup(30'h10);
      check("tp_sat_bpsel", 32'(o_bpsel), 32'd1);
      resolve(30'h10, 1, 30'h90, 1, 30'h80);
      check("tp_tgt_pd", 32'(o_pd), 32'd1);
      check("tp_tgt_rpc", 32'(o_rpc), 32'h90);
      lookup(30'h10);
      check("tp_tgt_bpa", 32'(o_bpa), 32'h90);

      // Same-cycle lookup and update to one index sees pre-edge contents
      cycle(0, 1, 30'h33, 1, 30'h33, 1, 30'h44, 0, 0);
      check("tp_bypass", 32'(o_bpsel), 32'd0);
      lookup(30'h33);
      check("tp_bypass_next", 32'(o_bpa), 32'h44);

      // Fall-through wraps at the top of the address space
      resolve(30'h3FFF_FFFF, 0, 0, 1, 30'h7);
      check("tp_wrap_rpc", 32'(o_rpc), 32'h0);
      check("tp_wrap_pd", 32'(o_pd), 32'd1);

      // Reset discards a mispredicting resolve
      cycle(1, 0, 0, 1, 30'h10, 1, 30'h123, 0, 0);
      check("tp_rst_pd", 32'(o_pd), 32'd0);
      check("tp_rst_mp", mp_count, 32'd0);
      lookup(30'h10);
      check("tp_rst_miss10", 32'(o_bpsel), 32'd0);
      lookup(30'h33);
      check("tp_rst_miss33", 32'(o_bpa), 32'd0);

      // Randomized traffic over a small PC pool to force hits and aliasing
      for (int n = 0; n < 600; n++) begin
         pc  = ($urandom_range(0, 9) == 0) ? longint'($urandom() & 32'h3FFF_FFFF)
                                            : longint'($urandom_range(0, 63));
         tgt = ($urandom_range(0, 1) == 0) ? longint'($urandom_range(0, 63))
                                            : longint'($urandom() & 32'h3FFF_FFFF);
         rt  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0) begin
            pt  = m_pred_taken(pc);
            ptg = m_pred_target(pc);
         end else begin
            pt  = 1'($urandom_range(0, 1));
            ptg = longint'($urandom_range(0, 63));
         end
         cycle($urandom_range(0, 59) == 0, 1'($urandom_range(0, 3) != 0),
               longint'($urandom_range(0, 63)),
               1'($urandom_range(0, 3) != 0), pc, rt, tgt, pt, ptg);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Sits beside the fetch-stage PC register:
  - Produces the predicted-taken select `bpSel` and predicted target `bp_a` that the PC consumes.
  - Produces the mispredict/recovery pair `pdStatus` and `rpc` that override the PC's next-PC choice.
- Trained by branch/jump resolutions arriving from the execute stage.
- All PCs are word addresses (byte PC bits [31:2], 30 bits wide).

Parameters:
- ENTRIES, 16, number of table entries; must be a power of two, minimum 2.
- IDX_W, $clog2(ENTRIES), index width; tag width TAG_W = 30 - IDX_W.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- lookup_en  in  1  fetch PC is valid this cycle.
- fetch_pc  in  30  current fetch word PC.
- bpSel  out  1  predict taken; redirect fetch to bp_a.
- bp_a  out  30  predicted target word PC.
- res_valid  in  1  a control-flow instruction resolves this cycle.
- res_pc  in  30  word PC of the resolving instruction.
- res_taken  in  1  actual direction.
- res_target  in  30  actual target word PC.
- res_pred_taken  in  1  bpSel value carried down the pipe with this instruction.
- res_pred_target  in  30  bp_a value carried down the pipe.
- pdStatus  out  1  mispredict; fetch must load rpc.
- rpc  out  30  recovery word PC.
- mp_count  out  32  saturating mispredict counter.

Behaviour:
- Interface (already decided): one clock, CLK; reset RST is synchronous and active-high.
- Entry contents: valid (1), tag (TAG_W), target (30), ctr (2).
- Address split: idx = pc[IDX_W-1:0]; tag = pc[29:IDX_W].
- Lookup (combinational, same cycle):
  - hit = lookup_en & valid[idx] & tag match.
  - bpSel = hit & ctr[1].
  - bp_a = target[idx] when hit; otherwise 0.
- Update (on rising CLK when res_valid & ~RST), entry selected by res_pc:
  - Hit, taken: ctr = min(ctr+1, 3); target = res_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate/overwrite; valid=1, tag=res_pc tag, target=res_target, ctr=2'b10 (weakly taken).
  - Miss, not taken: no change; no allocation.
- Mispredict (combinational, same cycle as res_valid):
  - pdStatus = res_valid & ~RST & ((res_taken != res_pred_taken) | (res_taken & res_pred_taken & res_target != res_pred_target)).
  - rpc = res_taken ? res_target : res_pc + 1, modulo 2^30 (0x3FFFFFFF + 1 = 0).
  - rpc = 0 when pdStatus = 0.
  - The PC gives pdStatus priority over bpSel.
- Simultaneous lookup and update to the same index: lookup returns pre-edge contents; no write-through bypass.
- mp_count: +1 on each cycle pdStatus = 1; saturates at 0xFFFFFFFF.
- Reset (RST = 1 at an edge):
  - All valid = 0, ctr = 2'b01, target = 0, tag = 0, mp_count = 0.
  - Any res_valid in a reset cycle is discarded: no update, pdStatus forced 0.
- Reset values of outputs: bpSel = 0, bp_a = 0, pdStatus = 0, rpc = 0, mp_count = 0.
- Latency:
  - Lookup: 0 cycles.
  - Training becomes visible to lookup 1 cycle after the resolving edge.
- At most one resolution per cycle; no backpressure, since the resolve port is always accepted.

Test Plan:
- Reset then lookup_en=1, fetch_pc=0x40 -> bpSel=0, bp_a=0, pdStatus=0, mp_count=0.
- Resolve res_pc=0x10, taken, res_target=0x80, pred_taken=0 -> same cycle pdStatus=1, rpc=0x80. Next cycle lookup 0x10 -> bpSel=1, bp_a=0x80; mp_count=1.
- Then resolve 0x10 not taken, pred_taken=1, pred_target=0x80 -> pdStatus=1, rpc=0x11. ctr becomes 01, so lookup 0x10 -> bpSel=0.
- Aliasing with ENTRIES=16:
  - Train 0x10 taken to 0x80; lookup 0x20 (same idx 0, different tag) -> bpSel=0.
  - Resolve 0x20 taken to 0x5 -> lookup 0x20 hits (bp_a=0x5); lookup 0x10 -> bpSel=0.
- Saturation and target change:
  - Four correct taken resolutions of 0x10, then one not-taken -> lookup still bpSel=1 (ctr=10).
  - Taken with res_target=0x90, pred_taken=1, pred_target=0x80 -> pdStatus=1, rpc=0x90; bp_a=0x90 next cycle.
- Wrap and reset:
  - res_pc=0x3FFFFFFF not taken, pred_taken=1 -> rpc=0x0.
  - RST=1 with a mispredicting res_valid -> pdStatus=0, mp_count=0; all subsequent lookups miss.
